// File: rtl/alu_add_arbiter.sv
// Round-robin arbiter sharing one alu_add among NumReq requesters.
// One operation in flight at a time; the grant is held until the response is taken.
package calc_pkg;
    typedef struct packed {
        logic        error;
        logic        sign;
        logic [15:0] mag;
    } num_t;
endpackage

module alu_add_arbiter
    import calc_pkg::*;
#(
    parameter int NumReq = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  num_t [NumReq-1:0]       req_left_i,
    input  num_t [NumReq-1:0]       req_right_i,
    input  logic [NumReq-1:0]       req_sub_i,
    input  logic [NumReq-1:0]       req_valid_i,
    output logic [NumReq-1:0]       req_ready_o,
    output num_t [NumReq-1:0]       rsp_result_o,
    output logic [NumReq-1:0]       rsp_valid_o,
    input  logic [NumReq-1:0]       rsp_ready_i,
    output num_t                    alu_left_o,
    output num_t                    alu_right_o,
    output logic                    alu_in_valid_o,
    input  logic                    alu_in_ready_i,
    input  num_t                    alu_result_i,
    input  logic                    alu_out_valid_i,
    output logic                    alu_out_ready_o
);

    localparam int IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESPOND = 2'd3
    } state_t;

    state_t            state_q;
    state_t            w_state_d;
    logic [IdxW-1:0]   grant_q;
    logic [IdxW-1:0]   rr_ptr_q;
    num_t              left_q;
    num_t              right_q;
    num_t              result_q;

    logic              w_any;
    logic [IdxW-1:0]   w_gnt;
    logic [IdxW-1:0]   w_idx;
    logic [IdxW-1:0]   w_rr_next;
    num_t              w_right;
    logic              w_rsp_fire;

    // Descending scan so the closest index at or after rr_ptr_q wins.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        w_idx = '0;
        for (int k = NumReq - 1; k >= 0; k--) begin
            w_idx = IdxW'((int'(rr_ptr_q) + k) % NumReq);
            if (req_valid_i[w_idx]) begin
                w_any = 1'b1;
                w_gnt = w_idx;
            end
        end
    end

    always_comb begin
        w_right      = req_right_i[w_gnt];
        w_right.sign = req_right_i[w_gnt].sign ^ req_sub_i[w_gnt];
    end

    assign w_rsp_fire = (state_q == S_RESPOND) && rsp_ready_i[grant_q];
    assign w_rr_next  = (grant_q == IdxW'(NumReq - 1)) ? '0
                                                        : grant_q + IdxW'(1);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = state_q;
        unique case (state_q)
            S_IDLE:    if (w_any)           w_state_d = S_ISSUE;
            S_ISSUE:   if (alu_in_ready_i)  w_state_d = S_WAIT;
            S_WAIT:    if (alu_out_valid_i) w_state_d = S_RESPOND;
            S_RESPOND: if (w_rsp_fire)      w_state_d = S_IDLE;
            default:                        w_state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            grant_q  <= '0;
            rr_ptr_q <= '0;
            left_q   <= '0;
            right_q  <= '0;
            result_q <= '0;
        end else begin
            if (state_q == S_IDLE && w_any) begin
                grant_q <= w_gnt;
                left_q  <= req_left_i[w_gnt];
                right_q <= w_right;
            end
            if (state_q == S_WAIT && alu_out_valid_i) begin
                result_q <= alu_result_i;
            end
            if (w_rsp_fire) begin
                rr_ptr_q <= w_rr_next;
            end
        end
    end

    // Ready is gated by reset so no handshake completes while held in reset.
    always_comb begin
        req_ready_o     = '0;
        rsp_valid_o     = '0;
        rsp_result_o    = '0;
        alu_in_valid_o  = 1'b0;
        alu_left_o      = '0;
        alu_right_o     = '0;
        alu_out_ready_o = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (w_any && rst_ni) begin
                    req_ready_o[w_gnt] = 1'b1;
                end
            end
            S_ISSUE: begin
                alu_in_valid_o = 1'b1;
                alu_left_o     = left_q;
                alu_right_o    = right_q;
            end
            S_WAIT: begin
                alu_out_ready_o = 1'b1;
            end
            S_RESPOND: begin
                rsp_valid_o[grant_q]  = 1'b1;
                rsp_result_o[grant_q] = result_q;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_add_arbiter.sv
// Directed bench for alu_add_arbiter with a behavioural alu_add stand-in.
// Numbers are sign-magnitude 8.8 fixed point.
module tb_alu_add_arbiter;
    import calc_pkg::*;

    localparam int N = 2;

    logic           clk = 1'b0;
    logic           rst_ni = 1'b0;
    num_t [N-1:0]   req_left_i;
    num_t [N-1:0]   req_right_i;
    logic [N-1:0]   req_sub_i;
    logic [N-1:0]   req_valid_i;
    logic [N-1:0]   req_ready_o;
    num_t [N-1:0]   rsp_result_o;
    logic [N-1:0]   rsp_valid_o;
    logic [N-1:0]   rsp_ready_i;
    num_t           alu_left_o;
    num_t           alu_right_o;
    logic           alu_in_valid_o;
    logic           alu_in_ready_i;
    num_t           alu_result_i;
    logic           alu_out_valid_i;
    logic           alu_out_ready_o;

    always #5 clk = ~clk;

    alu_add_arbiter #(.NumReq(N)) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .req_left_i      (req_left_i),
        .req_right_i     (req_right_i),
        .req_sub_i       (req_sub_i),
        .req_valid_i     (req_valid_i),
        .req_ready_o     (req_ready_o),
        .rsp_result_o    (rsp_result_o),
        .rsp_valid_o     (rsp_valid_o),
        .rsp_ready_i     (rsp_ready_i),
        .alu_left_o      (alu_left_o),
        .alu_right_o     (alu_right_o),
        .alu_in_valid_o  (alu_in_valid_o),
        .alu_in_ready_i  (alu_in_ready_i),
        .alu_result_i    (alu_result_i),
        .alu_out_valid_i (alu_out_valid_i),
        .alu_out_ready_o (alu_out_ready_o)
    );

    function automatic num_t mk(logic e, logic s, logic [15:0] m);
        num_t r;
        r.error = e;
        r.sign  = s;
        r.mag   = m;
        return r;
    endfunction

    function automatic num_t sm_add(num_t a, num_t b);
        int   va;
        int   vb;
        int   s;
        num_t r;
        va = a.sign ? -int'({16'h0, a.mag}) : int'({16'h0, a.mag});
        vb = b.sign ? -int'({16'h0, b.mag}) : int'({16'h0, b.mag});
        s  = va + vb;
        r.error = a.error | b.error;
        r.sign  = (s < 0);
        r.mag   = 16'((s < 0) ? -s : s);
        return r;
    endfunction

    // alu_add stand-in: one op at a time, result after alu_lat extra cycles
    logic tb_in_ready = 1'b1;
    int   alu_lat = 0;
    logic pend;
    int   cnt;
    num_t pres;
    int   issue_cnt = 0;
    num_t iss_l;
    num_t iss_r;

    assign alu_in_ready_i  = tb_in_ready & ~pend;
    assign alu_out_valid_i = pend && (cnt == 0);
    assign alu_result_i    = pres;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            pend <= 1'b0;
            cnt  <= 0;
            pres <= '0;
        end else begin
            if (alu_out_valid_i && alu_out_ready_o) pend <= 1'b0;
            else if (pend && cnt > 0) cnt <= cnt - 1;
            if (alu_in_valid_o && alu_in_ready_i) begin
                pend      <= 1'b1;
                pres      <= sm_add(alu_left_o, alu_right_o);
                cnt       <= alu_lat;
                issue_cnt <= issue_cnt + 1;
                iss_l     <= alu_left_o;
                iss_r     <= alu_right_o;
            end
        end
    end

    typedef struct {
        int   idx;
        num_t l;
        num_t r;
        logic sub;
        num_t exp_r;
        num_t exp_res;
    } vec_t;

    vec_t vt[6];
    int   n_vec = 0;
    int   n_bad = 0;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic do_req(int idx, num_t l, num_t r, logic sub);
        bit got = 1'b0;
        req_left_i[idx]  = l;
        req_right_i[idx] = r;
        req_sub_i[idx]   = sub;
        req_valid_i[idx] = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (req_ready_o[idx]) got = 1'b1;
        end
        chk("req_grant", 32'(got), 32'd1);
        if (got) begin
            chk("req_ready_onehot", 32'(req_ready_o), 32'd1 << idx);
            @(posedge clk);
            #1;
        end
        req_valid_i[idx] = 1'b0;
    endtask

    task automatic wait_rsp(int idx, output num_t res, output int cyc);
        bit got = 1'b0;
        cyc = 0;
        res = '0;
        for (int i = 0; i < 60 && !got; i++) begin
            @(negedge clk);
            cyc++;
            if (rsp_valid_o[idx]) begin
                got = 1'b1;
                res = rsp_result_o[idx];
                chk("rsp_valid_onehot", 32'(rsp_valid_o), 32'd1 << idx);
                chk("rsp_other_zero",
                    32'(rsp_result_o[1 - idx]), 32'd0);
            end
        end
        chk("rsp_seen", 32'(got), 32'd1);
        if (got) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        num_t res;
        int   cyc;
        int   c0;
        bit   got;

        req_left_i  = '0;
        req_right_i = '0;
        req_sub_i   = '0;
        req_valid_i = '0;
        rsp_ready_i = '1;

        vt[0] = '{0, mk(0,0,16'h0180), mk(0,0,16'h0240), 1'b0,
                  mk(0,0,16'h0240), mk(0,0,16'h03C0)};
        vt[1] = '{1, mk(0,0,16'h0500), mk(0,0,16'h0700), 1'b1,
                  mk(0,1,16'h0700), mk(0,1,16'h0200)};
        vt[2] = '{0, mk(0,1,16'h0300), mk(0,0,16'h0140), 1'b0,
                  mk(0,0,16'h0140), mk(0,1,16'h01C0)};
        vt[3] = '{1, mk(0,0,16'h0280), mk(0,1,16'h0100), 1'b1,
                  mk(0,0,16'h0100), mk(0,0,16'h0380)};
        vt[4] = '{0, mk(1,0,16'h0100), mk(0,0,16'h0100), 1'b0,
                  mk(0,0,16'h0100), mk(1,0,16'h0200)};
        vt[5] = '{1, mk(0,0,16'h0400), mk(0,0,16'h0400), 1'b1,
                  mk(0,1,16'h0400), mk(0,0,16'h0000)};

        // reset state, with requests pending
        repeat (2) @(negedge clk);
        req_valid_i = 2'b11;
        #1;
        chk("rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("rst_alu_in_valid", 32'(alu_in_valid_o), 32'd0);
        chk("rst_alu_out_ready", 32'(alu_out_ready_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("rst_alu_left", 32'(alu_left_o), 32'd0);
        chk("rst_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
        req_valid_i = '0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 6; i++) begin
            do_req(vt[i].idx, vt[i].l, vt[i].r, vt[i].sub);
            wait_rsp(vt[i].idx, res, cyc);
            chk($sformatf("v%0d_alu_left", i), 32'(iss_l), 32'(vt[i].l));
            chk($sformatf("v%0d_alu_right", i), 32'(iss_r),
                32'(vt[i].exp_r));
            chk($sformatf("v%0d_result", i), 32'(res), 32'(vt[i].exp_res));
            chk($sformatf("v%0d_latency", i), 32'(cyc), 32'd3);
            chk($sformatf("v%0d_rr_ptr", i), 32'(dut.rr_ptr_q),
                32'((vt[i].idx + 1) % N));
        end

        // both requesters valid continuously after reset
        @(negedge clk);
        rst_ni = 1'b0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        req_left_i[0]  = mk(0,0,16'h0100);
        req_right_i[0] = mk(0,0,16'h0100);
        req_sub_i[0]   = 1'b0;
        req_left_i[1]  = mk(0,0,16'h0300);
        req_right_i[1] = mk(0,0,16'h0080);
        req_sub_i[1]   = 1'b1;
        req_valid_i    = 2'b11;
        for (int t = 0; t < 4; t++) begin
            got = 1'b0;
            for (int i = 0; i < 50 && !got; i++) begin
                @(negedge clk);
                if (req_ready_o != '0) got = 1'b1;
            end
            chk($sformatf("alt%0d_grant", t), 32'(req_ready_o),
                (t % 2 == 1) ? 32'd2 : 32'd1);
            @(posedge clk);
            #1;
            wait_rsp(t % 2, res, cyc);
            chk($sformatf("alt%0d_result", t), 32'(res),
                (t % 2 == 1) ? 32'(mk(0,0,16'h0280))
                             : 32'(mk(0,0,16'h0200)));
        end
        req_valid_i = '0;

        // alu_in_ready_i held low for 5 cycles in S_ISSUE
        tb_in_ready = 1'b0;
        do_req(0, mk(0,0,16'h0200), mk(0,0,16'h0300), 1'b0);
        c0 = issue_cnt;
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            chk($sformatf("stall%0d_valid", c), 32'(alu_in_valid_o), 32'd1);
            chk($sformatf("stall%0d_left", c), 32'(alu_left_o),
                32'(mk(0,0,16'h0200)));
            chk($sformatf("stall%0d_right", c), 32'(alu_right_o),
                32'(mk(0,0,16'h0300)));
        end
        chk("stall_no_issue", 32'(issue_cnt), 32'(c0));
        tb_in_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_issue_c6", 32'(issue_cnt), 32'(c0 + 1));
        wait_rsp(0, res, cyc);
        chk("stall_result", 32'(res), 32'(mk(0,0,16'h0500)));

        // response back-pressure on requester 0 with requester 1 waiting
        rsp_ready_i[0] = 1'b0;
        do_req(0, mk(0,0,16'h0400), mk(0,0,16'h0100), 1'b1);
        req_left_i[1]  = mk(0,0,16'h0080);
        req_right_i[1] = mk(0,0,16'h0040);
        req_sub_i[1]   = 1'b0;
        req_valid_i[1] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (rsp_valid_o[0]) got = 1'b1;
        end
        chk("bp_rsp_seen", 32'(got), 32'd1);
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            chk($sformatf("bp%0d_valid", c), 32'(rsp_valid_o), 32'd1);
            chk($sformatf("bp%0d_result", c), 32'(rsp_result_o[0]),
                32'(mk(0,0,16'h0300)));
            chk($sformatf("bp%0d_no_grant", c), 32'(req_ready_o), 32'd0);
        end
        rsp_ready_i[0] = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("bp_req1_granted", 32'(req_ready_o), 32'd2);
        @(posedge clk);
        #1;
        req_valid_i[1] = 1'b0;
        wait_rsp(1, res, cyc);
        chk("bp_req1_result", 32'(res), 32'(mk(0,0,16'h00C0)));

        // reset pulsed in S_WAIT, then a fresh request completes
        alu_lat = 20;
        do_req(0, mk(0,0,16'h0100), mk(0,0,16'h0100), 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("mid_in_wait", 32'(alu_out_ready_o), 32'd1);
        req_valid_i[1] = 1'b1;
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_out_ready", 32'(alu_out_ready_o), 32'd0);
        chk("mid_rst_in_valid", 32'(alu_in_valid_o), 32'd0);
        chk("mid_rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        chk("mid_rst_req_ready", 32'(req_ready_o), 32'd0);
        chk("mid_rst_rr_ptr", 32'(dut.rr_ptr_q), 32'd0);
        req_valid_i = '0;
        alu_lat = 0;
        @(negedge clk);
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        do_req(1, mk(0,0,16'h0100), mk(0,0,16'h0100), 1'b0);
        wait_rsp(1, res, cyc);
        chk("post_rst_result", 32'(res), 32'(mk(0,0,16'h0200)));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_add_arbiter.md
ALU_ADD_ARBITER -- requirements
Module: alu_add_arbiter

Interface
REQ-001 The block SHALL have parameter NumReq, default 2, meaning the number of requesters sharing one alu_add instance.
REQ-002 The block SHALL have port clk_i, input, 1, the single clock; all state SHALL update on its rising edge.
REQ-003 The block SHALL have port rst_ni, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port req_left_i, input, NumReq x calc_pkg::num_t, the left operand per requester.
REQ-005 The block SHALL have port req_right_i, input, NumReq x calc_pkg::num_t, the right operand per requester.
REQ-006 The block SHALL have port req_sub_i, input, NumReq, where 1 = subtract (left - right) and 0 = add.
REQ-007 The block SHALL have ports req_valid_i (input, NumReq) and req_ready_o (output, NumReq), the request handshake.
REQ-008 The block SHALL have port rsp_result_o, output, NumReq x num_t, the result per requester.
REQ-009 The block SHALL have ports rsp_valid_o (output, NumReq) and rsp_ready_i (input, NumReq), the response handshake.
REQ-010 The block SHALL have ports alu_left_o and alu_right_o, output, num_t each, the operands driven to alu_add.
REQ-011 The block SHALL have ports alu_in_valid_o (output, 1) and alu_in_ready_i (input, 1), the alu_add input handshake.
REQ-012 The block SHALL have port alu_result_i, input, num_t, the alu_add result.
REQ-013 The block SHALL have ports alu_out_valid_i (input, 1) and alu_out_ready_o (output, 1), the alu_add output handshake.

Function
REQ-014 A transfer SHALL occur on any interface only in a cycle where its valid and ready are both 1.
REQ-015 The FSM SHALL have states S_IDLE, S_ISSUE, S_WAIT and S_RESPOND, with registers grant_q, rr_ptr_q, left_q, right_q and result_q.
REQ-016 In S_IDLE, the grant SHALL be the first index i with req_valid_i[i]=1, searching from rr_ptr_q upward modulo NumReq.
REQ-017 In S_IDLE, when any request is valid, the block SHALL assert req_ready_o[grant] combinationally for that one cycle and no other req_ready_o bit.
REQ-018 On that grant cycle the block SHALL capture the granted operands and move to S_ISSUE; with no valid request it SHALL stay in S_IDLE.
REQ-019 When req_sub_i[grant]=1, the captured right operand SHALL have its sign bit inverted and all other fields unchanged.
REQ-020 In S_ISSUE, alu_in_valid_o SHALL be 1 and alu_left_o/alu_right_o SHALL equal left_q/right_q.
REQ-021 In S_ISSUE, on alu_in_ready_i=1 the block SHALL move to S_WAIT; otherwise it SHALL hold valid and data stable.
REQ-022 Outside S_ISSUE, alu_in_valid_o SHALL be 0 and alu_left_o/alu_right_o SHALL be '0.
REQ-023 In S_WAIT, alu_out_ready_o SHALL be 1; on alu_out_valid_i=1 the block SHALL latch alu_result_i into result_q and move to S_RESPOND.
REQ-024 Outside S_WAIT, alu_out_ready_o SHALL be 0.
REQ-025 In S_RESPOND, rsp_valid_o[grant_q] SHALL be 1 and rsp_result_o[grant_q] SHALL equal result_q, held stable until rsp_ready_i[grant_q]=1.
REQ-026 All non-granted rsp_valid_o bits SHALL be 0, and all rsp_result_o entries not currently valid SHALL be '0.
REQ-027 On the response transfer, rr_ptr_q SHALL become (grant_q+1) mod NumReq and the FSM SHALL return to S_IDLE.
REQ-028 Minimum latency from request transfer to rsp_valid_o SHALL be 2 cycles plus the alu_add compute time; a new grant SHALL be possible in the cycle after a response transfer.
REQ-029 Requests arriving while the FSM is not in S_IDLE SHALL see req_ready_o=0 and SHALL wait; no request SHALL be dropped or duplicated.
REQ-030 Result fields, including error, SHALL pass through unmodified.

Reset
REQ-031 While rst_ni=0, state SHALL be S_IDLE, rr_ptr_q=0, grant_q=0, left_q=right_q=result_q='0, and all valid/ready outputs SHALL be 0.
REQ-032 Reset asserted mid-operation SHALL abandon the operation with no response; alu_add SHALL share the same system reset.

Verification
REQ-033 A bench SHALL cover: req0 adds 1.5 + 2.25 -> ALU receives those operands; rsp_valid_o[0]=1 with 3.75; rr_ptr=1.
REQ-034 A bench SHALL cover: req1 with sub=1 computes 5 - 7 -> ALU right operand sign=1; result -2.
REQ-035 A bench SHALL cover: both requests valid continuously after reset -> grants alternate 0,1,0,1 and each requester receives its own correct result.
REQ-036 A bench SHALL cover: alu_in_ready_i held 0 for 5 cycles in S_ISSUE -> alu_in_valid_o stays 1 with stable operands; issue occurs on cycle 6.
REQ-037 A bench SHALL cover: rsp_ready_i[0] held 0 for 10 cycles -> result held stable, req1 not granted; req1 is granted the cycle after the release.
REQ-038 A bench SHALL cover: rst_ni pulsed low during S_WAIT -> all outputs 0 immediately; after release a fresh request 1 + 1 -> 2 completes normally.
